// File: rtl/stream_conv2d.sv
// Streaming KxK 2-D convolution over a raster pixel stream with per-channel
// scale/saturate; two-stage pipeline under a single ready/valid enable.
module stream_conv2d #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int K           = 5,
    parameter int CH          = 3,
    parameter int CW          = 10,
    parameter int DW          = 8,
    parameter int COEF_W      = 32,
    parameter int BORDER_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [K*K*COEF_W-1:0]   coef,
    input  logic [4:0]              shift,
    input  logic [CH*CW-1:0]        x_data,
    input  logic                    x_valid,
    input  logic                    x_sof,
    output logic                    x_ready,
    output logic [CH*CW-1:0]        y_data,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic                    frame_done
);

    localparam int NT    = K * K;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PIX_W = CH * DW;
    localparam int PW    = DW + 1 + COEF_W;
    localparam int AW    = DW + COEF_W + $clog2(NT) + 1;

    logic                   en;
    logic                   xfer;
    logic [COL_W-1:0]       col, cur_col;
    logic [ROW_W-1:0]       row, cur_row;
    logic                   at_origin, complete, at_last;
    logic [PIX_W-1:0]       x_pix;
    logic [PIX_W-1:0]       col_vec [K];
    logic [PIX_W-1:0]       tap_pix [NT];
    logic [PIX_W-1:0]       win [K][K-1];
    logic [PIX_W-1:0]       lb [K-1][WIDTH];
    logic [NT*COEF_W-1:0]   coef_q, coef_sel;
    logic [4:0]             shift_q;

    logic                   v1, complete1, last1;
    logic [4:0]             shift1;
    logic [CH*CW-1:0]       pass1;
    logic signed [PW-1:0]   prod_d [CH][NT];
    logic signed [PW-1:0]   prod   [CH][NT];
    logic [CH*CW-1:0]       out_word;
    logic                   y_last;

    assign en      = y_ready | ~y_valid;
    assign x_ready = en;
    assign xfer    = x_valid & en;

    // x_sof forces this pixel to (0,0) whatever the counters say.
    assign cur_col   = x_sof ? '0 : col;
    assign cur_row   = x_sof ? '0 : row;
    assign at_origin = (cur_row == '0) && (cur_col == '0);
    assign complete  = (cur_row >= ROW_W'(K-1)) && (cur_col >= COL_W'(K-1));
    assign at_last   = (cur_row == ROW_W'(HEIGHT-1)) && (cur_col == COL_W'(WIDTH-1));
    assign coef_sel  = at_origin ? coef : coef_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        x_pix = '0;
        for (int ch = 0; ch < CH; ch++)
            x_pix[ch*DW +: DW] = x_data[ch*CW + (CW-DW) +: DW];
    end

    // Window row 0 is the oldest line; lb[j] holds the line j+1 above the input.
    always_comb begin
        col_vec = '{default: '0};
        tap_pix = '{default: '0};
        col_vec[K-1] = x_pix;
        for (int r = 0; r < K-1; r++)
            col_vec[r] = lb[K-2-r][cur_col];
        for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K-1; k++)
                tap_pix[r*K+k] = win[r][k];
            tap_pix[r*K+K-1] = col_vec[r];
        end
    end

    always_comb begin
        logic signed [PW-1:0] pe, ce;
        prod_d = '{default: '0};
        for (int ch = 0; ch < CH; ch++) begin
            for (int t = 0; t < NT; t++) begin
                pe = {{(PW-DW){1'b0}}, tap_pix[t][ch*DW +: DW]};
                ce = {{(PW-COEF_W){coef_sel[t*COEF_W+COEF_W-1]}}, coef_sel[t*COEF_W +: COEF_W]};
                prod_d[ch][t] = pe * ce;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row     <= '0;
            col     <= '0;
            coef_q  <= '0;
            shift_q <= '0;
        end else if (xfer) begin
            if (at_origin) begin
                coef_q  <= coef;
                shift_q <= shift;
            end
            if (cur_col == COL_W'(WIDTH-1)) begin
                col <= '0;
                row <= (cur_row == ROW_W'(HEIGHT-1)) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col <= cur_col + COL_W'(1);
                row <= cur_row;
            end
        end
    end

    // NOTE: line buffers, window and product registers are storage only and carry
    // no reset; incomplete windows never reach the output.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int j = K-2; j >= 1; j--)
                lb[j][cur_col] <= lb[j-1][cur_col];
            lb[0][cur_col] <= x_pix;
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K-2; k++)
                    win[r][k] <= win[r][k+1];
                win[r][K-2] <= col_vec[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en)
            prod <= prod_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            complete1 <= 1'b0;
            last1     <= 1'b0;
            shift1    <= '0;
            pass1     <= '0;
        end else if (en) begin
            v1        <= xfer;
            complete1 <= complete;
            last1     <= at_last;
            shift1    <= at_origin ? shift : shift_q;
            pass1     <= x_data;
        end
    end

    // Exact signed sum, arithmetic shift, then clamp into [0, 2^DW-1].
    always_comb begin
        logic signed [AW-1:0] acc, shd;
        logic [DW-1:0]        sat;
        logic [CH*CW-1:0]     result;
        result = '0;
        for (int ch = 0; ch < CH; ch++) begin
            acc = '0;
            for (int t = 0; t < NT; t++)
                acc = acc + {{(AW-PW){prod[ch][t][PW-1]}}, prod[ch][t]};
            shd = acc >>> shift1;
            if (shd[AW-1])
                sat = '0;
            else if (|shd[AW-2:DW])
                sat = '1;
            else
                sat = shd[DW-1:0];
            result[ch*CW +: CW] = {sat, {(CW-DW){1'b0}}};
        end
        if (complete1)
            out_word = result;
        else
            out_word = (BORDER_MODE == 1) ? pass1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid    <= 1'b0;
            y_data     <= '0;
            y_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (en) begin
                y_valid <= v1;
                y_data  <= out_word;
                y_last  <= v1 & last1;
            end
            frame_done <= y_valid & y_ready & y_last;
        end
    end

endmodule

// File: tb/tb_stream_conv2d.sv
// Directed bench for stream_conv2d (8x6 frame, 3x3 kernel), border modes 0 and 1
// driven side by side; expectations come from hand constants and a direct 2-D model.
module tb_stream_conv2d;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int K  = 3;
    localparam int NP = W * H;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [K*K*32-1:0]  coef;
    logic [4:0]         shift;
    logic [29:0]        x_data;
    logic               x_valid, x_sof, y_ready;
    logic               x_ready0, y_valid0, frame_done0;
    logic               x_ready1, y_valid1, frame_done1;
    logic [29:0]        y_data0, y_data1;

    int checks   = 0;
    int failures = 0;

    logic [29:0] img [H][W];
    int          coef_m [9];
    int          shift_m;
    logic [29:0] cap0 [$];
    logic [29:0] cap1 [$];
    logic [29:0] ref0 [$];
    logic [29:0] ref1 [$];
    int          capcyc [$];
    int          firecyc [$];
    int          cycle = 0;
    int          fd_count = 0;

    always #5 clk = ~clk;

    stream_conv2d #(.WIDTH(W), .HEIGHT(H), .K(K), .CH(3), .CW(10), .DW(8),
                    .COEF_W(32), .BORDER_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .coef(coef), .shift(shift),
        .x_data(x_data), .x_valid(x_valid), .x_sof(x_sof), .x_ready(x_ready0),
        .y_data(y_data0), .y_valid(y_valid0), .y_ready(y_ready),
        .frame_done(frame_done0));

    stream_conv2d #(.WIDTH(W), .HEIGHT(H), .K(K), .CH(3), .CW(10), .DW(8),
                    .COEF_W(32), .BORDER_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .coef(coef), .shift(shift),
        .x_data(x_data), .x_valid(x_valid), .x_sof(x_sof), .x_ready(x_ready1),
        .y_data(y_data1), .y_valid(y_valid1), .y_ready(y_ready),
        .frame_done(frame_done1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] pack_px(input logic [7:0] c0, input logic [7:0] c1,
                                            input logic [7:0] c2);
        return {c2, 2'b00, c1, 2'b00, c0, 2'b00};
    endfunction

    function automatic logic [29:0] mask_px(input logic [29:0] p);
        return p & 30'h3FCFF3FC;
    endfunction

    // Direct convolution over the stored image; window row i is image row r-2+i.
    function automatic logic [29:0] model_px(input int r, input int c);
        logic [29:0] res;
        longint      s, v;
        res = '0;
        if (r < K-1 || c < K-1)
            return res;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) begin
                    v = longint'(img[r-2+i][c-2+j][ch*10+2 +: 8]);
                    s = s + v * longint'(coef_m[i*K+j]);
                end
            s = s >>> shift_m;
            if (s < 0)
                s = 0;
            else if (s > 255)
                s = 255;
            res[ch*10+2 +: 8] = s[7:0];
        end
        return res;
    endfunction

    task automatic fill_ramp(input int seed);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = pack_px(8'(r*16 + c + seed), 8'(200 - r*20 - c*3 + seed),
                                    8'(r*c*9 + 17 + seed));
    endtask

    task automatic set_bus(input bit good);
        for (int t = 0; t < 9; t++)
            coef[t*32 +: 32] = good ? 32'(coef_m[t]) : (32'h5A5A_0000 ^ 32'(t));
        shift = good ? 5'(shift_m) : 5'd31;
    endtask

    task automatic step(input logic v, input logic [29:0] d, input logic sof,
                        input logic rdy, input bit good, output logic fired);
        @(negedge clk);
        x_valid = v;
        x_data  = d;
        x_sof   = sof;
        y_ready = rdy;
        set_bus(good);
        #1;
        fired = v && x_ready0;
        if (y_valid0 && y_ready) begin
            cap0.push_back(y_data0);
            cap1.push_back(y_data1);
            capcyc.push_back(cycle);
        end
        if (frame_done0)
            fd_count++;
        cycle++;
    endtask

    task automatic clear_caps();
        cap0.delete();
        cap1.delete();
        capcyc.delete();
        firecyc.delete();
        fd_count = 0;
    endtask

    task automatic send_frame(input bit rnd, input bit use_sof, input int last_n);
        logic fired;
        int   tries;
        for (int n = 0; n <= last_n; n++) begin
            if (rnd && $urandom_range(0, 3) == 0)
                step(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, fired);
            fired = 1'b0;
            tries = 0;
            while (!fired && tries < 200) begin
                step(1'b1, img[n/W][n%W], use_sof && (n == 0),
                     rnd ? 1'($urandom_range(0, 1)) : 1'b1, n == 0, fired);
                tries++;
            end
            check($sformatf("accept px%0d", n), 32'(fired), 32'd1);
            firecyc.push_back(cycle - 1);
        end
    endtask

    task automatic drain(input int n);
        logic fired;
        repeat (n) step(1'b0, '0, 1'b0, 1'b1, 1'b0, fired);
    endtask

    // Border mode 0 gives 0 on incomplete windows, mode 1 the input word.
    task automatic check_vs_model(input string tag);
        int r, c;
        check({tag, " count"}, 32'(cap0.size()), NP);
        for (int n = 0; n < cap0.size() && n < NP; n++) begin
            r = n / W;
            c = n % W;
            check($sformatf("%s m0 px%0d", tag, n), 32'(cap0[n]), 32'(model_px(r, c)));
            check($sformatf("%s m1 px%0d", tag, n), 32'(cap1[n]),
                  32'((r >= K-1 && c >= K-1) ? model_px(r, c) : img[r][c]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   r, c;
        logic [29:0] exp0, exp1;

        rst_n   = 1'b0;
        x_valid = 1'b0;
        x_sof   = 1'b0;
        x_data  = '0;
        y_ready = 1'b0;
        coef    = '0;
        shift   = '0;
        repeat (3) @(negedge clk);
        check("reset y_valid", 32'(y_valid0), 32'd0);
        check("reset y_data", 32'(y_data0), 32'd0);
        check("reset frame_done", 32'(frame_done0), 32'd0);
        check("reset x_ready", 32'(x_ready0), 32'd1);
        check("reset y_valid bm1", 32'(y_valid1), 32'd0);
        rst_n = 1'b1;

        // Identity kernel; output is the pixel one row up and one column left.
        coef_m  = '{0, 0, 0, 0, 1024, 0, 0, 0, 0};
        shift_m = 10;
        fill_ramp(0);
        img[0][3] = 30'h12345678;
        clear_caps();
        send_frame(1'b0, 1'b1, NP-1);
        drain(5);
        check("ident count", 32'(cap0.size()), NP);
        for (int n = 0; n < cap0.size() && n < NP; n++) begin
            r = n / W;
            c = n % W;
            exp0 = (r >= 2 && c >= 2) ? mask_px(img[r-1][c-1]) : 30'h0;
            exp1 = (r >= 2 && c >= 2) ? mask_px(img[r-1][c-1]) : img[r][c];
            check($sformatf("ident m0 px%0d", n), 32'(cap0[n]), 32'(exp0));
            check($sformatf("ident m1 px%0d", n), 32'(cap1[n]), 32'(exp1));
            check($sformatf("latency px%0d", n), 32'(capcyc[n] - firecyc[n]), 32'd2);
        end
        if (cap1.size() > 3)
            check("border pass (0,3)", 32'(cap1[3]), 32'h12345678);
        check("ident frame_done", 32'(fd_count), 32'd1);

        // Saturation high: 9*255*1024 >> 10 = 2295 -> 255 per channel.
        coef_m = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024};
        for (int rr = 0; rr < H; rr++)
            for (int cc = 0; cc < W; cc++)
                img[rr][cc] = pack_px(8'hFF, 8'hFF, 8'hFF);
        clear_caps();
        send_frame(1'b0, 1'b1, NP-1);
        drain(5);
        check("sat count", 32'(cap0.size()), NP);
        for (int n = 0; n < cap0.size() && n < NP; n++) begin
            r = n / W;
            c = n % W;
            exp0 = (r >= 2 && c >= 2) ? 30'h3FCFF3FC : 30'h0;
            check($sformatf("sat px%0d", n), 32'(cap0[n]), 32'(exp0));
        end

        // Saturation low: all-negative taps clamp every complete output to 0.
        coef_m = '{-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024};
        fill_ramp(3);
        clear_caps();
        send_frame(1'b0, 1'b1, NP-1);
        drain(5);
        check("neg count", 32'(cap0.size()), NP);
        for (int n = 0; n < cap0.size() && n < NP; n++) begin
            r = n / W;
            c = n % W;
            exp1 = (r >= 2 && c >= 2) ? 30'h0 : img[r][c];
            check($sformatf("neg m0 px%0d", n), 32'(cap0[n]), 32'd0);
            check($sformatf("neg m1 px%0d", n), 32'(cap1[n]), 32'(exp1));
        end

        // Mixed-sign kernel, free-flowing output: the reference sequence.
        coef_m  = '{-300, 512, 100, 256, 1500, -700, 64, 333, -50};
        shift_m = 9;
        fill_ramp(5);
        clear_caps();
        send_frame(1'b0, 1'b1, NP-1);
        drain(5);
        check_vs_model("mix");
        ref0 = cap0;
        ref1 = cap1;

        // Same frame twice with random backpressure and input bubbles.
        clear_caps();
        send_frame(1'b1, 1'b1, NP-1);
        send_frame(1'b1, 1'b1, NP-1);
        drain(6);
        check("bp count", 32'(cap0.size()), 2*NP);
        for (int n = 0; n < cap0.size() && n < 2*NP && ref0.size() == NP; n++) begin
            check($sformatf("bp m0 out%0d", n), 32'(cap0[n]), 32'(ref0[n % NP]));
            check($sformatf("bp m1 out%0d", n), 32'(cap1[n]), 32'(ref1[n % NP]));
        end
        check("bp frame_done", 32'(fd_count), 32'd2);

        // Abort mid-frame after pixel (3,4), then restart without x_sof.
        clear_caps();
        send_frame(1'b0, 1'b1, 3*W + 4);
        @(negedge clk);
        x_valid = 1'b0;
        check("pre-reset y_valid", 32'(y_valid0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset y_valid", 32'(y_valid0), 32'd0);
        check("mid reset y_data", 32'(y_data0), 32'd0);
        check("mid reset frame_done", 32'(frame_done0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        coef_m  = '{128, -256, 128, 512, 700, 512, -90, 40, -10};
        shift_m = 8;
        fill_ramp(11);
        clear_caps();
        send_frame(1'b0, 1'b0, NP-1);
        drain(5);
        check_vs_model("post-reset");
        check("post-reset frame_done", 32'(fd_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
